// File: rtl/dart_scoreboard_if.sv
// Throw, query and result signals of the dart scoreboard.
// The master drives throws and queries; the slave (the scoreboard) returns totals and results.
interface dart_scoreboard_if;
  logic       game_start;
  logic       score_valid;
  logic [2:0] player_id;
  logic [4:0] score_in;
  logic [2:0] query_id;
  logic [7:0] query_total;
  logic [1:0] state;
  logic       game_over;
  logic [2:0] winner_id;
  logic [7:0] winner_total;
  logic       tie;
  logic       error;

  modport master (
    output game_start, score_valid, player_id, score_in, query_id,
    input  query_total, state, game_over, winner_id, winner_total, tie, error
  );

  modport slave (
    input  game_start, score_valid, player_id, score_in, query_id,
    output query_total, state, game_over, winner_id, winner_total, tie, error
  );
endinterface

// File: rtl/dart_scoreboard.sv
// Dart game scoreboard: credits throws per player under a quota, then scans
// the totals one player per cycle to find the winner and flag ties.
module dart_scoreboard #(
  parameter int NUM_PLAYERS       = 3,
  parameter int THROWS_PER_PLAYER = 5
) (
  input  logic              clk,
  input  logic              reset,
  dart_scoreboard_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_TALLY = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] NP_L      = 4'(NUM_PLAYERS);
  localparam logic [3:0] TPP_L     = 4'(THROWS_PER_PLAYER);
  localparam logic [2:0] LAST_ID_L = 3'(NUM_PLAYERS - 1);

  state_e     state_q;
  logic [7:0] totals_q [8];
  logic [3:0] counts_q [8];
  logic [2:0] scan_idx_q;
  logic [2:0] winner_id_q;
  logic [7:0] winner_total_q;
  logic       tie_q;
  logic       error_q;
  logic       game_over_q;
  logic [7:0] query_total_q;

  logic       pid_ok_s;
  logic       quota_ok_s;
  logic       accept_s;
  logic       drop_s;
  logic [8:0] sum_s;
  logic [7:0] total_upd_d;
  logic       all_met_d;
  logic [7:0] scan_total_s;

  // Throw qualification, saturating add and quota completion check.
  always_comb begin
    pid_ok_s     = ({1'b0, bus.player_id} < NP_L);
    quota_ok_s   = (counts_q[bus.player_id] < TPP_L);
    accept_s     = (state_q == ST_PLAY) && bus.score_valid && !bus.game_start &&
                   pid_ok_s && quota_ok_s;
    drop_s       = (state_q == ST_PLAY) && bus.score_valid && !bus.game_start &&
                   !(pid_ok_s && quota_ok_s);
    sum_s        = {1'b0, totals_q[bus.player_id]} + {4'b0000, bus.score_in};
    total_upd_d  = sum_s[8] ? 8'hFF : sum_s[7:0];
    scan_total_s = totals_q[scan_idx_q];
    all_met_d    = 1'b1;
    // Counts as they will be after this edge, so the final throw moves straight to TALLY.
    for (int i = 0; i < 8; i++) begin
      if ((i < NUM_PLAYERS) &&
          ((counts_q[i] + ((accept_s && (bus.player_id == 3'(i))) ? 4'd1 : 4'd0)) != TPP_L)) begin
        all_met_d = 1'b0;
      end else begin
        all_met_d = all_met_d;
      end
    end
  end

  // Game FSM with totals, quotas, winner scan and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      scan_idx_q     <= 3'd0;
      winner_id_q    <= 3'd0;
      winner_total_q <= 8'd0;
      tie_q          <= 1'b0;
      error_q        <= 1'b0;
      game_over_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        totals_q[i] <= 8'd0;
        counts_q[i] <= 4'd0;
      end
    end else if (bus.game_start) begin
      state_q        <= ST_PLAY;
      scan_idx_q     <= 3'd0;
      winner_id_q    <= 3'd0;
      winner_total_q <= 8'd0;
      tie_q          <= 1'b0;
      error_q        <= 1'b0;
      game_over_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        totals_q[i] <= 8'd0;
        counts_q[i] <= 4'd0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        ST_PLAY: begin
          if (accept_s) begin
            totals_q[bus.player_id] <= total_upd_d;
            counts_q[bus.player_id] <= counts_q[bus.player_id] + 4'd1;
            if (all_met_d) begin
              state_q    <= ST_TALLY;
              scan_idx_q <= 3'd0;
            end
          end else if (drop_s) begin
            error_q <= 1'b1;
          end
        end
        ST_TALLY: begin
          // Player 0 seeds the scan so an all-zero first total is not counted as a tie.
          if (scan_idx_q == 3'd0) begin
            winner_id_q    <= 3'd0;
            winner_total_q <= scan_total_s;
            tie_q          <= 1'b0;
          end else if (scan_total_s > winner_total_q) begin
            winner_id_q    <= scan_idx_q;
            winner_total_q <= scan_total_s;
            tie_q          <= 1'b0;
          end else if (scan_total_s == winner_total_q) begin
            tie_q <= 1'b1;
          end
          if (scan_idx_q == LAST_ID_L) begin
            state_q     <= ST_DONE;
            game_over_q <= 1'b1;
          end else begin
            scan_idx_q <= scan_idx_q + 3'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered read-back of the queried player's total.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      query_total_q <= 8'd0;
    end else if ({1'b0, bus.query_id} < NP_L) begin
      query_total_q <= totals_q[bus.query_id];
    end else begin
      query_total_q <= 8'd0;
    end
  end

  assign bus.query_total  = query_total_q;
  assign bus.state        = state_q;
  assign bus.game_over    = game_over_q;
  assign bus.winner_id    = winner_id_q;
  assign bus.winner_total = winner_total_q;
  assign bus.tie          = tie_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_dart_scoreboard.sv
// Self-checking bench: vector table, directed game scenarios and random play
// against a game-level reference model, plus a 1-player/15-throw instance for saturation.
module tb_dart_scoreboard;

  localparam int N1 = 3;
  localparam int T1 = 5;

  logic clk;
  logic reset;

  dart_scoreboard_if if1 ();
  dart_scoreboard_if if2 ();

  dart_scoreboard #(.NUM_PLAYERS(N1), .THROWS_PER_PLAYER(T1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  dart_scoreboard #(.NUM_PLAYERS(1), .THROWS_PER_PLAYER(15)) dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Game-level reference model of dut1.
  int m_tot [8];
  int m_cnt [8];
  int m_state, m_cd, m_err, m_go, m_wid, m_wtot, m_tie, m_qt;

  typedef struct {
    logic       gs;
    logic       sv;
    logic [2:0] pid;
    logic [4:0] sc;
    logic [2:0] qid;
    int         st;
    int         err;
    int         qt;
  } vec_t;

  vec_t tbl [9];
  int   sweep_exp [8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_tot[i] = 0;
      m_cnt[i] = 0;
    end
    m_state = 0; m_cd = 0; m_err = 0; m_go = 0;
    m_wid = 0; m_wtot = 0; m_tie = 0; m_qt = 0;
  endtask

  task automatic model_edge(input logic gs, input logic sv, input int pid, input int sc, input int qid);
    int met, best, nbest;
    m_qt = (qid < N1) ? m_tot[qid] : 0;
    if (gs) begin
      for (int i = 0; i < 8; i++) begin
        m_tot[i] = 0;
        m_cnt[i] = 0;
      end
      m_state = 1; m_err = 0; m_go = 0; m_wid = 0; m_wtot = 0; m_tie = 0;
    end else if (m_state == 1) begin
      if (sv) begin
        if (pid < N1 && m_cnt[pid] < T1) begin
          m_tot[pid] = (m_tot[pid] + sc > 255) ? 255 : m_tot[pid] + sc;
          m_cnt[pid]++;
          met = 1;
          for (int i = 0; i < N1; i++) if (m_cnt[i] != T1) met = 0;
          if (met == 1) begin
            m_state = 2;
            m_cd = N1;
          end
        end else begin
          m_err = 1;
        end
      end
    end else if (m_state == 2) begin
      m_cd--;
      if (m_cd == 0) begin
        best = -1;
        for (int i = 0; i < N1; i++) begin
          if (m_tot[i] > best) begin
            best = m_tot[i];
            m_wid = i;
          end
        end
        nbest = 0;
        for (int i = 0; i < N1; i++) if (m_tot[i] == best) nbest++;
        m_wtot = best;
        m_tie = (nbest > 1) ? 1 : 0;
        m_state = 3;
        m_go = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("state", int'(if1.state), m_state);
    chk("game_over", int'(if1.game_over), m_go);
    chk("error", int'(if1.error), m_err);
    chk("query_total", int'(if1.query_total), m_qt);
    if (m_go == 1) begin
      chk("winner_id", int'(if1.winner_id), m_wid);
      chk("winner_total", int'(if1.winner_total), m_wtot);
      chk("tie", int'(if1.tie), m_tie);
    end
  endtask

  task automatic step(input logic gs, input logic sv, input logic [2:0] pid,
                      input logic [4:0] sc, input logic [2:0] qid);
    @(negedge clk);
    if1.game_start  = gs;
    if1.score_valid = sv;
    if1.player_id   = pid;
    if1.score_in    = sc;
    if1.query_id    = qid;
    @(posedge clk);
    model_edge(gs, sv, int'(pid), int'(sc), int'(qid));
    #1;
    check_all();
  endtask

  task automatic step2(input logic gs, input logic sv, input logic [4:0] sc);
    @(negedge clk);
    if2.game_start  = gs;
    if2.score_valid = sv;
    if2.player_id   = 3'd0;
    if2.score_in    = sc;
    if2.query_id    = 3'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, int'(if1.state), 0);
    chk({tag, "_game_over"}, int'(if1.game_over), 0);
    chk({tag, "_error"}, int'(if1.error), 0);
    chk({tag, "_query_total"}, int'(if1.query_total), 0);
    chk({tag, "_winner_id"}, int'(if1.winner_id), 0);
    chk({tag, "_winner_total"}, int'(if1.winner_total), 0);
    chk({tag, "_tie"}, int'(if1.tie), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    model_reset();
    reset = 1'b0;
    {if1.game_start, if1.score_valid, if1.player_id, if1.score_in, if1.query_id} = '0;
    {if2.game_start, if2.score_valid, if2.player_id, if2.score_in, if2.query_id} = '0;

    tbl[0] = '{1'b1, 1'b0, 3'd0, 5'd0,  3'd7, 1, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 3'd0, 5'd10, 3'd0, 1, 0, 0};
    tbl[2] = '{1'b0, 1'b1, 3'd5, 5'd3,  3'd0, 1, 1, 10};
    tbl[3] = '{1'b0, 1'b0, 3'd0, 5'd0,  3'd0, 1, 1, 10};
    tbl[4] = '{1'b1, 1'b1, 3'd0, 5'd7,  3'd0, 1, 0, 10};
    tbl[5] = '{1'b0, 1'b0, 3'd0, 5'd0,  3'd0, 1, 0, 0};
    tbl[6] = '{1'b0, 1'b1, 3'd2, 5'd31, 3'd2, 1, 0, 0};
    tbl[7] = '{1'b0, 1'b0, 3'd0, 5'd0,  3'd2, 1, 0, 31};
    tbl[8] = '{1'b0, 1'b1, 3'd3, 5'd1,  3'd3, 1, 1, 0};
    sweep_exp = '{50, 155, 50, 0, 0, 0, 0, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    chk("reset2_query_total", int'(if2.query_total), 0);
    chk("reset2_state", int'(if2.state), 0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1, 3'd0, 5'd9, 3'd0);
    chk("idle_holds", int'(if1.state), 0);

    // Saturation on the single-player, 15-throw instance
    step2(1'b1, 1'b0, 5'd0);
    for (int k = 0; k < 9; k++) step2(1'b0, 1'b1, 5'd31);
    chk("sat_pre", int'(if2.query_total), 248);
    step2(1'b0, 1'b0, 5'd0);
    chk("sat_255", int'(if2.query_total), 255);
    for (int k = 0; k < 5; k++) step2(1'b0, 1'b1, 5'd0);
    chk("sat_play", int'(if2.state), 1);
    step2(1'b0, 1'b1, 5'd0);
    chk("sat_tally", int'(if2.state), 2);
    step2(1'b0, 1'b0, 5'd0);
    chk("sat_done", int'(if2.state), 3);
    chk("sat_game_over", int'(if2.game_over), 1);
    chk("sat_winner_total", int'(if2.winner_total), 255);
    chk("sat_tie", int'(if2.tie), 0);
    step2(1'b0, 1'b1, 5'd5);
    chk("sat_done_ignore_err", int'(if2.error), 0);
    chk("sat_done_hold", int'(if2.query_total), 255);

    // Vector table: drops, game_start priority, query latency
    for (int v = 0; v < 9; v++) begin
      step(tbl[v].gs, tbl[v].sv, tbl[v].pid, tbl[v].sc, tbl[v].qid);
      chk($sformatf("vec%0d_state", v), int'(if1.state), tbl[v].st);
      chk($sformatf("vec%0d_error", v), int'(if1.error), tbl[v].err);
      chk($sformatf("vec%0d_qt", v), int'(if1.query_total), tbl[v].qt);
    end

    // Reset, then three-way tie at 15
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_all_zero("pulse");
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 3'd0, 5'd0, 3'd0);
    for (int k = 0; k < 15; k++) step(1'b0, 1'b1, 3'(k % 3), 5'd3, 3'(k % 3));
    chk("tie_tally_entry", int'(if1.state), 2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tie_go_low%0d", k), int'(if1.game_over), 0);
      step(1'b0, 1'b0, 3'd0, 5'd0, 3'(k));
      chk($sformatf("tie_total%0d", k), int'(if1.query_total), 15);
    end
    chk("tie_game_over", int'(if1.game_over), 1);
    chk("tie_winner_id", int'(if1.winner_id), 0);
    chk("tie_winner_total", int'(if1.winner_total), 15);
    chk("tie_flag", int'(if1.tie), 1);

    // Clear winner 155 vs 50/50, then query sweep
    step(1'b1, 1'b0, 3'd0, 5'd0, 3'd0);
    for (int r = 0; r < 5; r++) begin
      step(1'b0, 1'b1, 3'd0, 5'd10, 3'd0);
      step(1'b0, 1'b1, 3'd1, 5'd31, 3'd0);
      step(1'b0, 1'b1, 3'd2, 5'd10, 3'd0);
    end
    repeat (3) step(1'b0, 1'b0, 3'd0, 5'd0, 3'd0);
    chk("win_winner_id", int'(if1.winner_id), 1);
    chk("win_winner_total", int'(if1.winner_total), 155);
    chk("win_tie", int'(if1.tie), 0);
    chk("win_error", int'(if1.error), 0);
    for (int q = 0; q < 8; q++) begin
      step(1'b0, 1'b0, 3'd0, 5'd0, 3'(q));
      chk($sformatf("sweep_q%0d", q), int'(if1.query_total), sweep_exp[q]);
    end

    // Over-quota and out-of-range drops, sticky error
    step(1'b1, 1'b0, 3'd0, 5'd0, 3'd0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 3'd0, 5'd4, 3'd0);
    step(1'b0, 1'b1, 3'd0, 5'd9, 3'd0);
    chk("quota_error", int'(if1.error), 1);
    step(1'b0, 1'b1, 3'd5, 5'd9, 3'd0);
    step(1'b0, 1'b0, 3'd0, 5'd0, 3'd0);
    chk("drop_total_p0", int'(if1.query_total), 20);
    chk("drop_error_held", int'(if1.error), 1);
    step(1'b1, 1'b0, 3'd0, 5'd0, 3'd0);
    chk("drop_error_cleared", int'(if1.error), 0);

    // Asynchronous reset in the middle of TALLY
    for (int k = 0; k < 15; k++) step(1'b0, 1'b1, 3'(k % 3), 5'd1, 3'd0);
    step(1'b0, 1'b0, 3'd0, 5'd0, 3'd0);
    chk("mid_tally", int'(if1.state), 2);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all_zero("async");
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1, 3'd1, 5'd7, 3'd1);
    chk("post_reset_idle", int'(if1.state), 0);

    // Random play against the model
    step(1'b1, 1'b0, 3'd0, 5'd0, 3'd0);
    for (int c = 0; c < 2500; c++) begin
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)),
           3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
